fetch_queue_ctrl: RTL

FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

---
 rtl/fetch_queue_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_ctrl.sv
// Instruction prefetch controller: walks a fetch pointer through a combinational
// instruction memory and buffers {instruction, pc} pairs in a small circular queue.
module fetch_queue_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MEM_LIMIT  = 48
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FETCH_EN,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic [31:0]           IMEM_RD,
  output logic [31:0]           INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [3:0]            QCOUNT
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]           data;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  // Widened compare so an address near the top of the space is not wrapped into range.
  function automatic logic fits_limit(input logic [ADDR_WIDTH-1:0] addr);
    return (33'(addr) + 33'd4) <= 33'(MEM_LIMIT);
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [3:0]            count_q, count_d;
  entry_t                mem_q [DEPTH];

  logic   fpc_fits;
  logic   redir_fits;
  logic   push;
  logic   pop;
  entry_t head_entry;

  assign fpc_fits   = fits_limit(fpc_q);
  assign redir_fits = fits_limit(REDIRECT_ADDR);
  assign head_entry = mem_q[head_q];

  assign IMEM_ADDR   = fpc_q;
  assign QCOUNT      = count_q;
  assign INSTR_VALID = (count_q != 4'd0);
  assign INSTR       = INSTR_VALID ? head_entry.data : 32'd0;
  assign INSTR_PC    = INSTR_VALID ? head_entry.pc : '0;

  assign pop  = INSTR_VALID && INSTR_READY && !REDIRECT;
  assign push = (state_q == ST_RUN) && FETCH_EN && fpc_fits && !REDIRECT &&
                ((count_q < 4'(DEPTH)) || pop);

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!REDIRECT && FETCH_EN) state_d = ST_RUN;
      ST_RUN: begin
        if (!FETCH_EN)                   state_d = ST_IDLE;
        else if (!REDIRECT && !fpc_fits) state_d = ST_END;
      end
      ST_END:  if (REDIRECT && redir_fits) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (REDIRECT) begin
      // A redirect flushes everything queued and restarts at the word-aligned target.
      fpc_d   = {REDIRECT_ADDR[ADDR_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = 4'd0;
    end else begin
      if (push) begin
        fpc_d  = fpc_q + ADDR_WIDTH'(4);
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + 4'd1;
      else if (pop && !push) count_d = count_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      fpc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: queue storage is not reset; outputs are masked by INSTR_VALID so stale entries never show.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= '{data: IMEM_RD, pc: fpc_q};
  end

endmodule
